dec_strobe_gen: RTL and testbench

Parametrised, registered successor of the 3-to-8 enable decoder. It accepts a select code through a valid/ready handshake and drives a one-hot output vector in one of four modes: level hold, timed pulse, toggle latch, or clear. It sits between control or register-decode logic and per-channel strobe consumers such as enables, interrupt acknowledges and chip selects. Out-of-range select codes are rejected and can be reported.

---
 rtl/dec_strobe_pkg.sv | 16 +
 rtl/dec_strobe_gen_onehot.sv | 29 ++
 rtl/dec_strobe_gen.sv | 107 ++++++++++
 tb/tb_dec_strobe_gen.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/dec_strobe_pkg.sv
// Shared types for the dec_strobe_gen strobe generator: request modes and FSM states.
package dec_strobe_pkg;

  typedef enum logic [1:0] {
    MODE_LEVEL  = 2'b00,
    MODE_PULSE  = 2'b01,
    MODE_TOGGLE = 2'b10,
    MODE_CLEAR  = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_PULSE = 1'b1
  } state_e;

endpackage

// File: rtl/dec_strobe_gen_onehot.sv
// dec_onehot: combinational SEL_W -> OUT_W one-hot decoder with enable and range flag.
module dec_onehot #(
  parameter int SEL_W = 3,
  parameter int OUT_W = 8
) (
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output logic [OUT_W-1:0] oh,
  output logic             in_range
);

  // Compare at full select width plus one bit so OUT_W == 2**SEL_W is representable.
  localparam logic [SEL_W:0] OUT_LIM = (SEL_W+1)'(OUT_W);

  assign in_range = ({1'b0, sel} < OUT_LIM);

  // Decode an in-range, enabled select into a single asserted channel.
  always_comb begin
    oh = '0;
    for (int i = 0; i < OUT_W; i++) begin
      if (en && in_range && (sel == SEL_W'(i))) begin
        oh[i] = 1'b1;
      end else begin
        oh[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/dec_strobe_gen.sv
// dec_strobe_gen: registered one-hot strobe generator with LEVEL/PULSE/TOGGLE/CLEAR modes.
// Define DEC_STROBE_ERR_EN to build the sticky out-of-range err register.
module dec_strobe_gen
  import dec_strobe_pkg::*;
#(
  parameter int SEL_W     = 3,
  parameter int OUT_W     = 8,
  parameter int PULSE_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] out,
  output logic             busy,
  output logic             err
);

  localparam int CNT_W = $clog2(PULSE_LEN + 1);

  state_e             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [OUT_W-1:0]   out_r;
  logic [OUT_W-1:0]   oh_s;
  logic               in_range_s;
  mode_e              mode_s;

  assign mode_s = mode_e'(mode);

  dec_onehot #(
    .SEL_W (SEL_W),
    .OUT_W (OUT_W)
  ) u_onehot (
    .sel      (sel),
    .en       (en),
    .oh       (oh_s),
    .in_range (in_range_s)
  );

  // Request handling in IDLE and pulse countdown in PULSE; reset wins over an accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      out_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            case (mode_s)
              MODE_LEVEL:  out_r <= oh_s;
              MODE_PULSE: begin
                out_r <= oh_s;
                if (oh_s != '0) begin
                  state_r <= ST_PULSE;
                  cnt_r   <= CNT_W'(PULSE_LEN - 1);
                end
              end
              MODE_TOGGLE: out_r <= (en && in_range_s) ? (out_r ^ oh_s) : out_r;
              MODE_CLEAR:  out_r <= '0;
              default:     out_r <= '0;
            endcase
          end
        end
        ST_PULSE: begin
          // cnt reaching zero marks the last high cycle; drop out and reopen for requests.
          if (cnt_r == '0) begin
            out_r   <= '0;
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= '0;
          out_r   <= '0;
        end
      endcase
    end
  end

`ifdef DEC_STROBE_ERR_EN
  logic err_r;

  // Sticky flag for any accepted out-of-range select, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (in_valid && (state_r == ST_IDLE) && !in_range_s) begin
      err_r <= 1'b1;
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

  assign out      = out_r;
  assign in_ready = (state_r == ST_IDLE);
  assign busy     = (state_r == ST_PULSE);

endmodule

// File: tb/tb_dec_strobe_gen.sv
// Directed self-checking bench for dec_strobe_gen: 8-channel/PULSE_LEN=4 and 6-channel/PULSE_LEN=1 instances.
module tb_dec_strobe_gen;

`ifdef DEC_STROBE_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, en;
  logic [2:0] sel;
  logic [1:0] mode;
  logic [7:0] out0;
  logic       ready0, busy0, err0;

  logic       v1_valid, v1_en;
  logic [2:0] v1_sel;
  logic [1:0] v1_mode;
  logic [5:0] out1;
  logic       ready1, busy1, err1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dec_strobe_gen #(.SEL_W(3), .OUT_W(8), .PULSE_LEN(4)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready0), .sel(sel),
    .en(en), .mode(mode), .out(out0), .busy(busy0), .err(err0)
  );

  dec_strobe_gen #(.SEL_W(3), .OUT_W(6), .PULSE_LEN(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(v1_valid), .in_ready(ready1), .sel(v1_sel),
    .en(v1_en), .mode(v1_mode), .out(out1), .busy(busy1), .err(err1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; sel = 3'd5; en = 1'b1; mode = 2'b00;
    v1_valid = 1'b0; v1_en = 1'b0; v1_sel = 3'd0; v1_mode = 2'b00;

    // Reset held with a pending request
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_out", 32'(out0), 32'h00);
      chk("rst_ready", 32'(ready0), 32'd1);
      chk("rst_err", 32'(err0), 32'd0);
      chk("rst_busy", 32'(busy0), 32'd0);
    end
    rst = 1'b0; in_valid = 1'b0;
    step();
    chk("post_rst_out", 32'(out0), 32'h00);
    chk("u1_rst_err", 32'(err1), 32'd0);

    // LEVEL
    in_valid = 1'b1; mode = 2'b00; sel = 3'd5; en = 1'b1;
    step();
    chk("level_sel5", 32'(out0), 32'h20);
    sel = 3'd2; en = 1'b0;
    step();
    chk("level_en0", 32'(out0), 32'h00);
    sel = 3'd7; en = 1'b1;
    step();
    chk("level_sel7", 32'(out0), 32'h80);
    mode = 2'b11;
    step();
    chk("clear0", 32'(out0), 32'h00);

    // PULSE with a request held during the pulse
    mode = 2'b01; sel = 3'd0; en = 1'b1;
    step();
    chk("pulse_c1_out", 32'(out0), 32'h01);
    chk("pulse_c1_busy", 32'(busy0), 32'd1);
    chk("pulse_c1_ready", 32'(ready0), 32'd0);
    mode = 2'b00; sel = 3'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("pulse_hold_out", 32'(out0), 32'h01);
      chk("pulse_hold_busy", 32'(busy0), 32'd1);
      chk("pulse_hold_ready", 32'(ready0), 32'd0);
    end
    step();
    chk("pulse_end_out", 32'(out0), 32'h00);
    chk("pulse_end_busy", 32'(busy0), 32'd0);
    chk("pulse_end_ready", 32'(ready0), 32'd1);
    step();
    chk("reaccept_out", 32'(out0), 32'h08);
    mode = 2'b11;
    step();
    chk("clear1", 32'(out0), 32'h00);

    // TOGGLE
    mode = 2'b10; sel = 3'd1; en = 1'b1;
    step();
    chk("tog_1a", 32'(out0), 32'h02);
    step();
    chk("tog_1b", 32'(out0), 32'h00);
    sel = 3'd7;
    step();
    chk("tog_7", 32'(out0), 32'h80);
    en = 1'b0; sel = 3'd2;
    step();
    chk("tog_en0", 32'(out0), 32'h80);
    mode = 2'b11; sel = 3'd1;
    step();
    chk("tog_clear", 32'(out0), 32'h00);

    // PULSE with en=0 stays idle
    mode = 2'b01; en = 1'b0; sel = 3'd4;
    step();
    chk("pulse_zero_out", 32'(out0), 32'h00);
    chk("pulse_zero_ready", 32'(ready0), 32'd1);
    chk("pulse_zero_busy", 32'(busy0), 32'd0);

    // Reset in the second cycle of a pulse
    en = 1'b1; sel = 3'd2;
    step();
    chk("mid_c1_out", 32'(out0), 32'h04);
    in_valid = 1'b0;
    step();
    chk("mid_c2_busy", 32'(busy0), 32'd1);
    rst = 1'b1;
    step();
    chk("mid_rst_out", 32'(out0), 32'h00);
    chk("mid_rst_busy", 32'(busy0), 32'd0);
    chk("mid_rst_ready", 32'(ready0), 32'd1);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("no_residual_out", 32'(out0), 32'h00);
      chk("no_residual_busy", 32'(busy0), 32'd0);
    end
    chk("u0_err", 32'(err0), 32'd0);

    // OUT_W=6 instance: out-of-range select and err flag
    v1_valid = 1'b1; v1_mode = 2'b00; v1_sel = 3'd6; v1_en = 1'b1;
    step();
    chk("u1_sel6_out", 32'(out1), 32'h00);
    chk("u1_sel6_err", 32'(err1), 32'(ERR_ON));
    v1_sel = 3'd5;
    step();
    chk("u1_sel5_out", 32'(out1), 32'h20);
    chk("u1_sticky_err", 32'(err1), 32'(ERR_ON));
    v1_mode = 2'b01; v1_sel = 3'd0;
    step();
    chk("u1_pulse_out", 32'(out1), 32'h01);
    chk("u1_pulse_busy", 32'(busy1), 32'd1);
    v1_valid = 1'b0;
    step();
    chk("u1_pulse_end_out", 32'(out1), 32'h00);
    chk("u1_pulse_end_ready", 32'(ready1), 32'd1);
    v1_valid = 1'b1; v1_sel = 3'd7;
    step();
    chk("u1_sel7_out", 32'(out1), 32'h00);
    chk("u1_sel7_ready", 32'(ready1), 32'd1);
    chk("u1_sel7_err", 32'(err1), 32'(ERR_ON));
    v1_valid = 1'b0;
    step();
    chk("u1_hold_err", 32'(err1), 32'(ERR_ON));
    rst = 1'b1;
    step();
    chk("u1_rst_clr_err", 32'(err1), 32'd0);
    rst = 1'b0;
    step();
    chk("u1_after_rst_err", 32'(err1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
